// File: rtl/lifo_fifo_buffer_if.sv
// rtl/lifo_fifo_buffer_if.sv - command/data bundle between a buffer user and lifo_fifo_buffer
//
// Purpose: groups the push/pop commands, write data and status of the buffer.
// Signals:
//   init      master->slave  synchronous clear of contents/pointers
//   push      master->slave  write data_in this cycle
//   pop       master->slave  remove top (stack) / head (queue) this cycle
//   data_in   master->slave  word to push
//   data_out  slave->master  current top / head, 0 when empty
//   full      slave->master  buffer holds DEPTH entries
//   empty     slave->master  buffer holds no entries
interface lifo_fifo_buffer_if #(
  parameter int WIDTH = 2
);
  logic             init;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output init, push, pop, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  init, push, pop, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// rtl/lifo_fifo_buffer.sv - move-code buffer with compile-time stack or queue personality
//
// Purpose: stores WIDTH-bit words and replays them last-in-first-out (MODE=0)
//   or first-in-first-out (MODE=1). Single-cycle push/pop, combinational
//   top/head output, full/empty decoded from the entry count.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset of pointers and count
//   bus   lifo_fifo_buffer_if.slave: init, push, pop, data_in in;
//         data_out, full, empty out
module lifo_fifo_buffer #(
  parameter int MODE  = 0,
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  lifo_fifo_buffer_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Storage has no reset: its contents are meaningless until written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          empty, full;
  logic          pop_ok, push_ok, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A push into a full buffer is still legal when a pop frees a slot the same edge.
  assign pop_ok  = bus.pop && !empty;
  assign push_ok = bus.push && (!full || pop_ok);
  assign wr_en   = !bus.init && push_ok;

  always_comb begin
    count_d = count_q;
    if (bus.init) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (MODE == 0) begin : g_stack
      // The stack pointer is the count; the top lives one below it.
      // With count == DEPTH the low AW bits are 0, so top_idx wraps to DEPTH-1.
      logic [AW-1:0] top_idx;
      assign top_idx = count_q[AW-1:0] - AW'(1);
      // Push+pop replaces the top in place instead of moving the pointer.
      assign wr_addr = pop_ok ? top_idx : count_q[AW-1:0];
      assign rd_addr = top_idx;
    end else begin : g_queue
      logic [AW-1:0] wr_ptr_q, wr_ptr_d;
      logic [AW-1:0] rd_ptr_q, rd_ptr_d;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.init) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      assign wr_addr = wr_ptr_q;
      assign rd_addr = rd_ptr_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.data_in;
    end
  end

  assign bus.data_out = empty ? '0 : mem_q[rd_addr];
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// tb/tb_lifo_fifo_buffer.sv - self-checking bench for stack and queue personalities
module tb_lifo_fifo_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lifo_fifo_buffer_if #(.WIDTH(2)) s_if ();
  lifo_fifo_buffer_if #(.WIDTH(2)) q_if ();

  lifo_fifo_buffer #(.MODE(0), .WIDTH(2), .DEPTH(256), .AW(8)) u_stk (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  lifo_fifo_buffer #(.MODE(1), .WIDTH(2), .DEPTH(256), .AW(8)) u_que (
    .clk (clk),
    .rst (rst),
    .bus (q_if)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] sm[$];
  logic [1:0] qm[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [1:0] s_exp, q_exp;
    s_exp = (sm.size() > 0) ? sm[sm.size()-1] : 2'b00;
    q_exp = (qm.size() > 0) ? qm[0] : 2'b00;
    check("stk_dout",  32'(s_if.data_out), 32'(s_exp));
    check("stk_empty", 32'(s_if.empty),    32'(sm.size() == 0));
    check("stk_full",  32'(s_if.full),     32'(sm.size() == 256));
    check("que_dout",  32'(q_if.data_out), 32'(q_exp));
    check("que_empty", 32'(q_if.empty),    32'(qm.size() == 0));
    check("que_full",  32'(q_if.full),     32'(qm.size() == 256));
  endtask

  // One clock with the given commands, reference update at the edge, then compare.
  task automatic cyc(input logic i, input logic ps, input logic pp,
                     input logic [1:0] ds, input logic [1:0] dq);
    logic s_pop, s_push, q_pop, q_push;
    s_if.init = i;  q_if.init = i;
    s_if.push = ps; q_if.push = ps;
    s_if.pop  = pp; q_if.pop  = pp;
    s_if.data_in = ds;
    q_if.data_in = dq;
    @(posedge clk);
    if (i) begin
      sm.delete();
      qm.delete();
    end else begin
      s_pop  = pp && (sm.size() > 0);
      s_push = ps && ((sm.size() < 256) || s_pop);
      if (s_push && s_pop) sm[sm.size()-1] = ds;
      else if (s_push)     sm.push_back(ds);
      else if (s_pop)      void'(sm.pop_back());
      q_pop  = pp && (qm.size() > 0);
      q_push = ps && ((qm.size() < 256) || q_pop);
      if (q_pop)  void'(qm.pop_front());
      if (q_push) qm.push_back(dq);
    end
    #1;
    s_if.init = 1'b0; q_if.init = 1'b0;
    s_if.push = 1'b0; q_if.push = 1'b0;
    s_if.pop  = 1'b0; q_if.pop  = 1'b0;
    check_all();
  endtask

  task automatic push2(input logic [1:0] d);
    cyc(1'b0, 1'b1, 1'b0, d, d);
  endtask

  task automatic pop1();
    cyc(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
  endtask

  logic [1:0] t1_in  [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
  logic [1:0] t1_stk [4] = '{2'b01, 2'b00, 2'b11, 2'b00};
  logic [1:0] t1_que [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

  initial begin
    s_if.init = 1'b0; s_if.push = 1'b0; s_if.pop = 1'b0; s_if.data_in = 2'b00;
    q_if.init = 1'b0; q_if.push = 1'b0; q_if.pop = 1'b0; q_if.data_in = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_stk_empty", 32'(s_if.empty),    32'd1);
    check("rst_stk_full",  32'(s_if.full),     32'd0);
    check("rst_stk_dout",  32'(s_if.data_out), 32'd0);
    check("rst_que_empty", 32'(q_if.empty),    32'd1);
    check("rst_que_full",  32'(q_if.full),     32'd0);
    check("rst_que_dout",  32'(q_if.data_out), 32'd0);
    rst = 1'b1;

    // 1: init, push 11,00,01,10, pop four times
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) push2(t1_in[k]);
    check("t1_stk_top",   32'(s_if.data_out), 32'h2);
    check("t1_que_head",  32'(q_if.data_out), 32'h3);
    check("t1_stk_empty", 32'(s_if.empty),    32'd0);
    for (int k = 0; k < 4; k++) begin
      pop1();
      check("t1_stk_pop", 32'(s_if.data_out), 32'(t1_stk[k]));
      check("t1_que_pop", 32'(q_if.data_out), 32'(t1_que[k]));
    end
    check("t1_stk_empty_end", 32'(s_if.empty), 32'd1);
    check("t1_que_empty_end", 32'(q_if.empty), 32'd1);

    // 2: pop when empty, then push 01; push+pop while empty acts as push
    pop1();
    pop1();
    check("t2_stk_dout0", 32'(s_if.data_out), 32'd0);
    check("t2_que_empty", 32'(q_if.empty),    32'd1);
    push2(2'b01);
    check("t2_stk_dout1", 32'(s_if.data_out), 32'h1);
    check("t2_que_dout1", 32'(q_if.data_out), 32'h1);
    pop1();
    cyc(1'b0, 1'b1, 1'b1, 2'b10, 2'b10);
    check("t2_stk_pp_empty", 32'(s_if.data_out), 32'h2);
    check("t2_que_pp_empty", 32'(q_if.data_out), 32'h2);
    pop1();

    // 3: fill with random words, overflow push ignored, drain
    for (int k = 0; k < 256; k++) push2(2'($urandom_range(0, 3)));
    check("t3_stk_full", 32'(s_if.full), 32'd1);
    check("t3_que_full", 32'(q_if.full), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
    check("t3_stk_full_257", 32'(s_if.full), 32'd1);
    for (int k = 0; k < 256; k++) pop1();

    // 4: queue wrap - fill, pop 4, push 4, drain
    for (int k = 0; k < 256; k++) push2(2'($urandom_range(0, 3)));
    for (int k = 0; k < 4; k++) pop1();
    for (int k = 0; k < 4; k++) push2(2'(k));
    check("t4_que_full_again", 32'(q_if.full), 32'd1);
    for (int k = 0; k < 256; k++) pop1();
    check("t4_que_empty", 32'(q_if.empty), 32'd1);

    // 5: simultaneous push+pop on a partly filled and on a full buffer
    push2(2'b01);
    push2(2'b10);
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 2'b11);
    check("t5_stk_replace", 32'(s_if.data_out), 32'h3);
    check("t5_que_head",    32'(q_if.data_out), 32'h2);
    for (int k = 0; k < 254; k++) push2(2'($urandom_range(0, 3)));
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 2'(k), 2'(k + 1));
    check("t5_que_full_pp", 32'(q_if.full), 32'd1);
    for (int k = 0; k < 256; k++) pop1();

    // 6: init pulse (with a push that must be ignored), then async reset mid-sequence
    for (int k = 0; k < 5; k++) push2(2'b10);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 2'b11);
    check("t6_init_stk_empty", 32'(s_if.empty),    32'd1);
    check("t6_init_que_dout",  32'(q_if.data_out), 32'd0);
    push2(2'b11);
    push2(2'b01);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_stk_empty", 32'(s_if.empty),    32'd1);
    check("t6_rst_stk_dout",  32'(s_if.data_out), 32'd0);
    check("t6_rst_que_empty", 32'(q_if.empty),    32'd1);
    check("t6_rst_que_full",  32'(q_if.full),     32'd0);
    check("t6_rst_que_dout",  32'(q_if.data_out), 32'd0);
    sm.delete();
    qm.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    push2(2'b10);
    check("t6_post_stk", 32'(s_if.data_out), 32'h2);
    check("t6_post_que", 32'(q_if.data_out), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
